dcache_controller: RTL and testbench
====================================

// Module: dcache_controller
// PURPOSE
//  Direct-mapped, write-back, write-allocate data cache between the CPU MEM stage and the
//  off-chip data memory. Replaces the single-cycle data memory port: hits complete same cycle,
//  misses assert cpu_stall_o, which freezes the whole pipeline until the line is serviced.
// PARAMETERS
//  NUM_LINES   32   lines in cache (power of 2); index = log2(NUM_LINES) bits
//  LINE_BYTES  32   bytes per line (power of 2, >=8); memory-side data width = 8*LINE_BYTES
//  ADDR_W      32   byte-address width; tag = ADDR_W - index - offset bits
// PORTS
//  clk_i        in   1          clock, all state updates on posedge
//  rst_i        in   1          synchronous reset, active-low
//  cpu_req_i    in   1          MEM-stage access valid (MemRead | MemWrite)
//  cpu_we_i     in   1          1 = store, 0 = load
//  cpu_addr_i   in   ADDR_W     byte address; bits [1:0] ignored
//  cpu_wdata_i  in   32         store data
//  cpu_rdata_o  out  32         load data, valid when cpu_req_i & ~cpu_stall_o
//  cpu_stall_o  out  1          1 = hold pipeline, CPU inputs must stay stable
//  mem_req_o    out  1          memory request valid
//  mem_we_o     out  1          1 = line write-back, 0 = line fetch
//  mem_addr_o   out  ADDR_W     line-aligned address (offset bits zero)
//  mem_wdata_o  out  8*LINE_BYTES  victim line data
//  mem_rdata_i  in   8*LINE_BYTES  fetched line data, valid with mem_ack_i
//  mem_ack_i    in   1          one-cycle completion pulse
//  hit_cnt_o    out  32         hit counter (see CONFIGURATION)
//  miss_cnt_o   out  32         miss counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_i==0 at posedge): state=IDLE, all valid/dirty bits 0, mem_req_o=0, mem_we_o=0,
//   mem_addr_o=0, counters=0; cpu_rdata_o=0, cpu_stall_o=0. Tag/data arrays not cleared.
//   Reset mid-miss abandons the memory transaction; reset wins over a same-cycle mem_ack_i.
//  hit = valid[idx] & tag[idx]==addr tag. Word select = addr[offset-1:2].
//  cpu_stall_o = (state!=IDLE) | (cpu_req_i & ~hit); combinational.
//  IDLE: read hit -> cpu_rdata_o = word, 0 stall cycles. Write hit -> word written and
//   dirty[idx]=1 at posedge. Miss & dirty victim -> WRITEBACK; miss & clean -> ALLOCATE.
//  WRITEBACK: mem_req_o=1, mem_we_o=1, addr={victim tag,idx,0}, wdata=victim line;
//   on mem_ack_i -> ALLOCATE, mem_req_o low for exactly one cycle between transactions.
//  ALLOCATE: mem_req_o=1, mem_we_o=0, addr={req tag,idx,0}; on mem_ack_i capture line,
//   set tag, valid=1, dirty=0 -> UPDATE.
//  UPDATE: one cycle, stall held; -> IDLE, where the access replays as a hit (store then
//   merges word and sets dirty). Miss latency = write-back ack + allocate ack + 2 cycles.
//  mem_req_o/mem_addr_o/mem_wdata_o stable from assertion until ack; mem_ack_i outside
//   WRITEBACK/ALLOCATE is ignored. cpu_req_i dropping mid-miss does not abort the refill.
// CONFIGURATION
//  DCACHE_STATS_EN defined: hit_cnt_o increments once per IDLE hit that is not the replay
//   following UPDATE; miss_cnt_o increments on each IDLE->WRITEBACK/ALLOCATE transition;
//   both saturate at 32'hFFFF_FFFF. Undefined: no counter flops, both outputs tied to 0.
// STRUCTURE
//  dcache_pkg: state enum {IDLE,WRITEBACK,ALLOCATE,UPDATE}, derived widths
//   (OFFSET_W, INDEX_W, TAG_W, LINE_W) as functions of the parameters.
//  Sub-module dcache_line_store: tag/valid/dirty/data arrays, async read, sync write,
//   word-merge write port and full-line fill port. Controller holds FSM, muxes, counters.
// TESTING
//  1 Cold read 0x0000_0040, mem returns line with word0=0x1234_5678 after 3 cycles ->
//    stall high through UPDATE, then rdata=0x1234_5678, no write-back issued, miss_cnt=1.
//  2 Store 0xDEAD_BEEF to 0x40 then load 0x44 and 0x40 -> no stall, 0x40 reads 0xDEAD_BEEF,
//    dirty[2]=1, hit_cnt=3 with stats enabled.
//  3 Load 0x0000_0440 (same idx 2, new tag) after test 2 -> WRITEBACK addr 0x40 with
//    word0=0xDEAD_BEEF first, then ALLOCATE addr 0x440; miss_cnt increments by 1.
//  4 Assert rst_i=0 during ALLOCATE with mem_ack_i=1 same cycle -> IDLE, mem_req_o=0,
//    subsequent load 0x40 misses (valid cleared).
//  5 Back-to-back pipeline: lw/sw/lw hitting 3 different lines after warm-up -> zero stalls;
//    compile without DCACHE_STATS_EN -> hit_cnt_o=miss_cnt_o=0 throughout.

Source files
------------

// File: rtl/dcache_pkg.sv
// ============================================================================
//  Module      : dcache_pkg
//  Description : Shared types and width helpers for the direct-mapped data cache.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package dcache_pkg;

    localparam int C_DEF_NUM_LINES  = 32;
    localparam int C_DEF_LINE_BYTES = 32;
    localparam int C_DEF_ADDR_W     = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    function automatic int calc_offset_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int calc_index_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int calc_tag_w(input int addr_w, input int num_lines, input int line_bytes);
        return addr_w - $clog2(num_lines) - $clog2(line_bytes);
    endfunction

    function automatic int calc_line_w(input int line_bytes);
        return 8 * line_bytes;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_line_store.sv
// ============================================================================
//  Module      : dcache_line_store
//  Description : Tag/valid/dirty/data arrays; async read, word-merge and line-fill writes.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int NUM_LINES  = C_DEF_NUM_LINES,
    parameter int LINE_BYTES = C_DEF_LINE_BYTES,
    parameter int ADDR_W     = C_DEF_ADDR_W,
    parameter int INDEX_W    = calc_index_w(NUM_LINES),
    parameter int TAG_W      = calc_tag_w(ADDR_W, NUM_LINES, LINE_BYTES),
    parameter int LINE_W     = calc_line_w(LINE_BYTES),
    parameter int WSEL_W     = calc_offset_w(LINE_BYTES) - 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INDEX_W-1:0] rd_idx_i,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic               rd_valid_o,
    output logic               rd_dirty_o,
    output logic [LINE_W-1:0]  rd_line_o,
    input  logic               wr_en_i,
    input  logic [INDEX_W-1:0] wr_idx_i,
    input  logic [WSEL_W-1:0]  wr_word_i,
    input  logic [31:0]        wr_data_i,
    input  logic               fill_en_i,
    input  logic [INDEX_W-1:0] fill_idx_i,
    input  logic [TAG_W-1:0]   fill_tag_i,
    input  logic [LINE_W-1:0]  fill_line_i
);

    localparam int C_WORDS = LINE_BYTES / 4;

    logic [TAG_W-1:0]     tag_q   [NUM_LINES];
    logic [LINE_W-1:0]    data_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;

    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_dirty_o = dirty_q[rd_idx_i];
    assign rd_line_o  = data_q[rd_idx_i];

    // Only the status bits are reset; tag and data contents survive reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en_i) begin
            valid_q[fill_idx_i] <= 1'b1;
            dirty_q[fill_idx_i] <= 1'b0;
        end else if (wr_en_i) begin
            dirty_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i && fill_en_i) begin
            tag_q[fill_idx_i]  <= fill_tag_i;
            data_q[fill_idx_i] <= fill_line_i;
        end else if (wr_en_i) begin
            for (int w = 0; w < C_WORDS; w++) begin
                if (wr_word_i == WSEL_W'(w)) begin
                    data_q[wr_idx_i][w*32 +: 32] <= wr_data_i;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dcache_controller.sv
// ============================================================================
//  Module      : dcache_controller
//  Description : Direct-mapped write-back/write-allocate data cache controller.
//                Optional hit/miss statistics enabled by defining DCACHE_STATS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dcache_controller
    import dcache_pkg::*;
#(
    parameter int NUM_LINES  = C_DEF_NUM_LINES,
    parameter int LINE_BYTES = C_DEF_LINE_BYTES,
    parameter int ADDR_W     = C_DEF_ADDR_W
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cpu_req_i,
    input  logic                         cpu_we_i,
    input  logic [ADDR_W-1:0]            cpu_addr_i,
    input  logic [31:0]                  cpu_wdata_i,
    output logic [31:0]                  cpu_rdata_o,
    output logic                         cpu_stall_o,
    output logic                         mem_req_o,
    output logic                         mem_we_o,
    output logic [ADDR_W-1:0]            mem_addr_o,
    output logic [8*LINE_BYTES-1:0]      mem_wdata_o,
    input  logic [8*LINE_BYTES-1:0]      mem_rdata_i,
    input  logic                         mem_ack_i,
    output logic [31:0]                  hit_cnt_o,
    output logic [31:0]                  miss_cnt_o
);

    localparam int OFFSET_W = calc_offset_w(LINE_BYTES);
    localparam int INDEX_W  = calc_index_w(NUM_LINES);
    localparam int TAG_W    = calc_tag_w(ADDR_W, NUM_LINES, LINE_BYTES);
    localparam int LINE_W   = calc_line_w(LINE_BYTES);
    localparam int WSEL_W   = OFFSET_W - 2;
    localparam int C_WORDS  = LINE_BYTES / 4;

    state_t              state_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [TAG_W-1:0]    miss_tag_q;
    logic [INDEX_W-1:0]  miss_idx_q;
    logic                replay_q;

    logic [INDEX_W-1:0]  w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [WSEL_W-1:0]   w_wsel;
    logic [INDEX_W-1:0]  w_rd_idx;
    logic [TAG_W-1:0]    w_rd_tag;
    logic                w_rd_valid;
    logic                w_rd_dirty;
    logic [LINE_W-1:0]   w_rd_line;
    logic [31:0]         w_word;
    logic                w_hit;
    logic                w_idle;
    logic                w_wr_en;
    logic                w_fill_en;
    logic                w_count_hit;
    logic                w_count_miss;
    logic                w_unused;

    assign w_idx    = cpu_addr_i[OFFSET_W +: INDEX_W];
    assign w_tag    = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign w_wsel   = cpu_addr_i[2 +: WSEL_W];
    assign w_unused = ^cpu_addr_i[1:0];

    // Outside IDLE the array is addressed by the latched miss so the victim stays put.
    assign w_idle    = (state_q == IDLE);
    assign w_rd_idx  = w_idle ? w_idx : miss_idx_q;
    assign w_hit     = w_rd_valid && (w_rd_tag == w_tag);
    assign w_wr_en   = w_idle && cpu_req_i && cpu_we_i && w_hit;
    assign w_fill_en = (state_q == ALLOCATE) && mem_req_q && mem_ack_i;

    always_comb begin
        w_word = '0;
        for (int w = 0; w < C_WORDS; w++) begin
            if (w_wsel == WSEL_W'(w)) begin
                w_word = w_rd_line[w*32 +: 32];
            end
        end
    end

    assign cpu_stall_o = !w_idle || (cpu_req_i && !w_hit);
    assign cpu_rdata_o = (w_idle && cpu_req_i && w_hit) ? w_word : 32'd0;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = w_rd_line;

    dcache_line_store #(
        .NUM_LINES  (NUM_LINES),
        .LINE_BYTES (LINE_BYTES),
        .ADDR_W     (ADDR_W),
        .INDEX_W    (INDEX_W),
        .TAG_W      (TAG_W),
        .LINE_W     (LINE_W),
        .WSEL_W     (WSEL_W)
    ) u_store (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_idx_i    (w_rd_idx),
        .rd_tag_o    (w_rd_tag),
        .rd_valid_o  (w_rd_valid),
        .rd_dirty_o  (w_rd_dirty),
        .rd_line_o   (w_rd_line),
        .wr_en_i     (w_wr_en),
        .wr_idx_i    (w_idx),
        .wr_word_i   (w_wsel),
        .wr_data_i   (cpu_wdata_i),
        .fill_en_i   (w_fill_en),
        .fill_idx_i  (miss_idx_q),
        .fill_tag_i  (miss_tag_q),
        .fill_line_i (mem_rdata_i)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            replay_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    replay_q <= 1'b0;
                    if (cpu_req_i && !w_hit) begin
                        miss_tag_q <= w_tag;
                        miss_idx_q <= w_idx;
                        mem_req_q  <= 1'b1;
                        if (w_rd_valid && w_rd_dirty) begin
                            state_q    <= WRITEBACK;
                            mem_we_q   <= 1'b1;
                            mem_addr_q <= {w_rd_tag, w_idx, {OFFSET_W{1'b0}}};
                        end else begin
                            state_q    <= ALLOCATE;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= {w_tag, w_idx, {OFFSET_W{1'b0}}};
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        state_q   <= ALLOCATE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                ALLOCATE: begin
                    // Arriving from WRITEBACK the request starts one cycle late, leaving a gap.
                    if (!mem_req_q) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {miss_tag_q, miss_idx_q, {OFFSET_W{1'b0}}};
                    end else if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= UPDATE;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    replay_q <= 1'b1;
                end
            endcase
        end
    end

    assign w_count_hit  = w_idle && cpu_req_i && w_hit && !replay_q;
    assign w_count_miss = w_idle && cpu_req_i && !w_hit;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (w_count_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (w_count_miss && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_count_hit ^ w_count_miss ^ replay_q;
    assign hit_cnt_o      = 32'd0;
    assign miss_cnt_o     = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_controller.sv
// ============================================================================
//  Module      : tb_dcache_controller
//  Description : Directed, table-driven bench for dcache_controller with a line memory model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dcache_controller;

    localparam int LW = 256;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          cpu_req_i = 1'b0;
    logic          cpu_we_i = 1'b0;
    logic [31:0]   cpu_addr_i = '0;
    logic [31:0]   cpu_wdata_i = '0;
    logic [31:0]   cpu_rdata_o;
    logic          cpu_stall_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [31:0]   mem_addr_o;
    logic [LW-1:0] mem_wdata_o;
    logic [LW-1:0] mem_rdata_i = '0;
    logic          mem_ack_i = 1'b0;
    logic [31:0]   hit_cnt_o;
    logic [31:0]   miss_cnt_o;

    dcache_controller u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .hit_cnt_o   (hit_cnt_o),
        .miss_cnt_o  (miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

`ifdef DCACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    // Backing memory: 64 lines of 8 words, line index = addr[10:5].
    logic [LW-1:0] mem_model [64];
    bit            auto_mem = 1'b1;
    int            mem_lat  = 3;
    int            wait_cnt = 0;
    logic          log_we   [$];
    logic [31:0]   log_addr [$];
    logic [31:0]   log_w0   [$];
    logic [31:0]   log_w1   [$];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [7];

    function automatic logic [31:0] exp_cnt(input logic [31:0] v);
        return STATS ? v : 32'd0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory responder: acks mem_lat cycles after a request is seen.
    initial begin
        forever begin
            @(negedge clk_i);
            if (auto_mem) begin
                if (mem_ack_i) begin
                    mem_ack_i = 1'b0;
                    wait_cnt  = 0;
                end else if (mem_req_o) begin
                    wait_cnt++;
                    if (wait_cnt >= mem_lat) begin
                        wait_cnt = 0;
                        log_we.push_back(mem_we_o);
                        log_addr.push_back(mem_addr_o);
                        log_w0.push_back(mem_wdata_o[31:0]);
                        log_w1.push_back(mem_wdata_o[63:32]);
                        if (mem_we_o) mem_model[mem_addr_o[10:5]] = mem_wdata_o;
                        else          mem_rdata_i = mem_model[mem_addr_o[10:5]];
                        mem_ack_i = 1'b1;
                    end
                end else begin
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic clear_log();
        log_we.delete();
        log_addr.delete();
        log_w0.delete();
        log_w1.delete();
    endtask

    task automatic do_miss(input logic [31:0] a, input int exp_cyc, input logic [31:0] exp_rd,
                           input string nm);
        int cyc;
        @(negedge clk_i);
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = a;
        #1;
        chk({nm, "_stall_on_miss"}, 32'(cpu_stall_o), 32'd1);
        cyc = 0;
        while (cpu_stall_o && cyc < 100) begin
            @(posedge clk_i);
            #1;
            cyc++;
        end
        chk({nm, "_stall_cycles"}, 32'(cyc), 32'(exp_cyc));
        chk({nm, "_rdata"}, cpu_rdata_o, exp_rd);
        @(negedge clk_i);
        cpu_req_i = 1'b0;
    endtask

    task automatic apply(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk_i);
            cpu_req_i   = 1'b1;
            cpu_we_i    = tbl[i].we;
            cpu_addr_i  = tbl[i].addr;
            cpu_wdata_i = tbl[i].wdata;
            #1;
            chk($sformatf("vec%0d_stall", i), 32'(cpu_stall_o), 32'd0);
            if (tbl[i].chk_rd) chk($sformatf("vec%0d_rdata", i), cpu_rdata_o, tbl[i].exp_rd);
        end
        @(negedge clk_i);
        cpu_req_i = 1'b0;
        cpu_we_i  = 1'b0;
    endtask

    initial begin
        for (int l = 0; l < 64; l++)
            for (int w = 0; w < 8; w++)
                mem_model[l][w*32 +: 32] = 32'h1000_0000 + 32'(l * 256 + w);
        mem_model[2][31:0] = 32'h1234_5678;

        tbl[0] = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 32'h0000_0044, 32'h0,         1'b1, 32'h1000_0201};
        tbl[2] = '{1'b0, 32'h0000_0040, 32'h0,         1'b1, 32'hDEAD_BEEF};
        tbl[3] = '{1'b0, 32'h0000_0440, 32'h0,         1'b1, 32'h1000_2200};
        tbl[4] = '{1'b1, 32'h0000_0084, 32'hCAFE_F00D, 1'b0, 32'h0};
        tbl[5] = '{1'b0, 32'h0000_00C8, 32'h0,         1'b1, 32'h1000_0602};
        tbl[6] = '{1'b0, 32'h0000_0084, 32'h0,         1'b1, 32'hCAFE_F00D};

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_stall", 32'(cpu_stall_o), 32'd0);
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_mem_we", 32'(mem_we_o), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_rdata", cpu_rdata_o, 32'd0);
        chk("rst_hit_cnt", hit_cnt_o, 32'd0);
        chk("rst_miss_cnt", miss_cnt_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Cold read miss, clean victim
        clear_log();
        do_miss(32'h0000_0040, 5, 32'h1234_5678, "cold");
        chk("cold_txn_count", 32'(log_addr.size()), 32'd1);
        chk("cold_txn_we", 32'(log_we[0]), 32'd0);
        chk("cold_txn_addr", log_addr[0], 32'h0000_0040);
        chk("cold_miss_cnt", miss_cnt_o, exp_cnt(32'd1));

        // Store/load hits on the filled line
        apply(0, 2);
        chk("hits_hit_cnt", hit_cnt_o, exp_cnt(32'd3));
        chk("hits_miss_cnt", miss_cnt_o, exp_cnt(32'd1));

        // Conflict miss on dirty line: write-back then allocate
        clear_log();
        do_miss(32'h0000_0440, 9, 32'h1000_2200, "evict");
        chk("evict_txn_count", 32'(log_addr.size()), 32'd2);
        chk("evict_wb_we", 32'(log_we[0]), 32'd1);
        chk("evict_wb_addr", log_addr[0], 32'h0000_0040);
        chk("evict_wb_word0", log_w0[0], 32'hDEAD_BEEF);
        chk("evict_wb_word1", log_w1[0], 32'h1000_0201);
        chk("evict_alloc_we", 32'(log_we[1]), 32'd0);
        chk("evict_alloc_addr", log_addr[1], 32'h0000_0440);
        chk("evict_miss_cnt", miss_cnt_o, exp_cnt(32'd2));

        // Warm two more lines, then a back-to-back lw/sw/lw stream
        do_miss(32'h0000_0080, 5, 32'h1000_0400, "warm80");
        do_miss(32'h0000_00C0, 5, 32'h1000_0600, "warmC0");
        apply(3, 6);
        chk("stream_hit_cnt", hit_cnt_o, exp_cnt(32'd7));
        chk("stream_miss_cnt", miss_cnt_o, exp_cnt(32'd4));

        // Reset during ALLOCATE with a coincident ack
        @(negedge clk_i);
        auto_mem   = 1'b0;
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0000_0100;
        @(posedge clk_i);
        #1;
        chk("alloc_req", 32'(mem_req_o), 32'd1);
        chk("alloc_we", 32'(mem_we_o), 32'd0);
        chk("alloc_addr", mem_addr_o, 32'h0000_0100);
        chk("alloc_stall", 32'(cpu_stall_o), 32'd1);
        @(negedge clk_i);
        rst_i       = 1'b0;
        mem_ack_i   = 1'b1;
        mem_rdata_i = '1;
        cpu_req_i   = 1'b0;
        @(posedge clk_i);
        #1;
        chk("midrst_req", 32'(mem_req_o), 32'd0);
        chk("midrst_addr", mem_addr_o, 32'd0);
        chk("midrst_stall", 32'(cpu_stall_o), 32'd0);
        chk("midrst_hit_cnt", hit_cnt_o, 32'd0);
        chk("midrst_miss_cnt", miss_cnt_o, 32'd0);
        @(negedge clk_i);
        rst_i     = 1'b1;
        mem_ack_i = 1'b0;
        auto_mem  = 1'b1;

        // Valid bits cleared: both the abandoned line and the earlier line miss
        do_miss(32'h0000_0100, 5, 32'h1000_0800, "postrst100");
        clear_log();
        do_miss(32'h0000_0040, 5, 32'hDEAD_BEEF, "postrst40");
        chk("postrst_no_wb", 32'(log_addr.size()), 32'd1);
        chk("postrst_miss_cnt", miss_cnt_o, exp_cnt(32'd2));
        chk("postrst_hit_cnt", hit_cnt_o, 32'd0);

        repeat (2) @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
